// File: rtl/pod_kinematics_integrator_pkg.sv
// rtl/pod_kinematics_integrator_pkg.sv - pod_model_pkg: state codes and rig-wide constants
// Shared with the sensor emulators so they agree on reset and track-end positions.
package pod_model_pkg;

  localparam logic [1:0] POD_IDLE  = 2'b00;
  localparam logic [1:0] POD_RUN   = 2'b01;
  localparam logic [1:0] POD_LIMIT = 2'b10;

  localparam int          POD_CLK_HZ    = 50_000_000;
  localparam logic [63:0] POD_POS_INIT  = 64'd15_240_000_000;
  localparam logic [63:0] POD_POS_LIMIT = 64'd381_000_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pod_kinematics_integrator_if.sv
// rtl/pod_kinematics_integrator_if.sv - control and state bundle of the pod motion model
// master drives accel/run/preload, slave (the integrator) returns motion state.
interface pod_kinematics_integrator_if #(
  parameter int ACC_W = 32,
  parameter int VEL_W = 32,
  parameter int POS_W = 64
);

  logic signed [ACC_W-1:0] accel;
  logic                    running;
  logic                    load;
  logic        [POS_W-1:0] load_pos;
  logic        [POS_W-1:0] position;
  logic        [VEL_W-1:0] velocity;
  logic        [VEL_W-1:0] pos_step;
  logic        [1:0]       state;
  logic                    at_limit;

  modport master (
    output accel, running, load, load_pos,
    input  position, velocity, pos_step, state, at_limit
  );

  modport slave (
    input  accel, running, load, load_pos,
    output position, velocity, pos_step, state, at_limit
  );

endinterface

// File: rtl/pod_kinematics_integrator_udiv.sv
// rtl/pod_kinematics_integrator_udiv.sv - pod_seq_udiv: restoring divider by a constant
// One quotient bit per clock; done pulses WIDTH+1 cycles after start, start while busy restarts.
module pod_seq_udiv #(
  parameter int WIDTH   = 32,
  parameter int DIVISOR = 100
) (
  input  logic             clk_50Mhz,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int             CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] DIV_C = (WIDTH + 1)'(DIVISOR);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   trial;

  // quo doubles as the dividend shift register; its MSB feeds the partial remainder.
  assign trial = {rem, quo[WIDTH-1]};

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      rem  <= '0;
      quo  <= '0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      done <= 1'b0;
      rem  <= '0;
      quo  <= dividend;
      cnt  <= '0;
    end else if (busy) begin
      if (cnt == CNT_W'(WIDTH)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        if (trial >= DIV_C) begin
          rem <= WIDTH'(trial - DIV_C);
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= WIDTH'(trial);
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
        cnt <= cnt + 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/pod_kinematics_integrator.sv
// rtl/pod_kinematics_integrator.sv - pod velocity/position integrator with run/freeze FSM
// POD_LIMIT_EN: stop at POS_LIMIT and enter LIMIT; otherwise position wraps and at_limit is 0.
module pod_kinematics_integrator
  import pod_model_pkg::*;
#(
  parameter int               CLK_HZ      = POD_CLK_HZ,
  parameter int               VEL_TICK_HZ = 1_000,
  parameter int               POS_TICK_HZ = 100_000,
  parameter int               ACC_W       = 32,
  parameter int               VEL_W       = 32,
  parameter int               POS_W       = 64,
  parameter int               POS_DIV     = 100,
  parameter logic [VEL_W-1:0] VEL_MAX     = '1,
  parameter logic [POS_W-1:0] POS_INIT    = POS_W'(POD_POS_INIT),
  parameter logic [POS_W-1:0] POS_LIMIT   = POS_W'(POD_POS_LIMIT)
) (
  input  logic                        clk_50Mhz,
  input  logic                        rst_n,
  pod_kinematics_integrator_if.slave  pod
);

  localparam int VEL_PERIOD = CLK_HZ / VEL_TICK_HZ;
  localparam int POS_PERIOD = CLK_HZ / POS_TICK_HZ;
  localparam int VCNT_W     = $clog2(VEL_PERIOD + 1);
  localparam int PCNT_W     = $clog2(POS_PERIOD + 1);
  localparam int SUM_W      = max_int(ACC_W, VEL_W) + 2;

  localparam logic signed [SUM_W-1:0] VEL_MAX_EXT = signed'(SUM_W'(VEL_MAX));

  logic [1:0]        state_q, state_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [VEL_W-1:0]  vel_q, vel_d;
  logic [VEL_W-1:0]  step_q, step_d;
  logic [VCNT_W-1:0] vel_cnt;
  logic [PCNT_W-1:0] pos_cnt;

  logic                    counting;
  logic                    vel_tick;
  logic                    pos_tick;
  logic signed [SUM_W-1:0] vel_sum;
  logic [VEL_W-1:0]        vel_clamped;

  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [VEL_W-1:0] div_quot;

  assign counting = (state_q == POD_RUN) && pod.running;
  assign vel_tick = counting && (vel_cnt == VCNT_W'(VEL_PERIOD - 1));
  assign pos_tick = counting && (pos_cnt == PCNT_W'(POS_PERIOD - 1));

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      vel_cnt <= '0;
      pos_cnt <= '0;
    end else if (!counting) begin
      vel_cnt <= '0;
      pos_cnt <= '0;
    end else begin
      vel_cnt <= vel_tick ? '0 : vel_cnt + 1'b1;
      pos_cnt <= pos_tick ? '0 : pos_cnt + 1'b1;
    end
  end

  // Wide enough that velocity + most-negative accel can never wrap before the clamp.
  assign vel_sum = signed'(SUM_W'(vel_q)) + SUM_W'(pod.accel);

  always_comb begin
    vel_clamped = vel_sum[VEL_W-1:0];
    if (vel_sum[SUM_W-1]) begin
      vel_clamped = '0;
    end else if (vel_sum > VEL_MAX_EXT) begin
      vel_clamped = VEL_MAX;
    end
  end

`ifdef POD_LIMIT_EN
  logic [POS_W:0] pos_sum;
  assign pos_sum = {1'b0, pos_q} + (POS_W + 1)'(step_q);
`else
  logic [POS_W-1:0] pos_sum;
  assign pos_sum = pos_q + POS_W'(step_q);

  if (POS_LIMIT == '0) begin : g_track_end_unused
  end
`endif

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    vel_d   = vel_q;
    step_d  = step_q;
    if (div_done && !div_busy) begin
      step_d = div_quot;
    end
    case (state_q)
      POD_IDLE: begin
        if (pod.load) begin
          pos_d  = pod.load_pos;
          vel_d  = '0;
          step_d = '0;
        end
        if (pod.running) begin
          state_d = POD_RUN;
        end
      end
      POD_RUN: begin
        if (!pod.running) begin
          state_d = POD_IDLE;
        end else begin
          if (vel_tick) begin
            vel_d = vel_clamped;
          end
          if (pos_tick) begin
`ifdef POD_LIMIT_EN
            if (pos_sum >= {1'b0, POS_LIMIT}) begin
              pos_d   = POS_LIMIT;
              vel_d   = '0;
              step_d  = '0;
              state_d = POD_LIMIT;
            end else begin
              pos_d = pos_sum[POS_W-1:0];
            end
`else
            pos_d = pos_sum;
`endif
          end
        end
      end
`ifdef POD_LIMIT_EN
      POD_LIMIT: begin
        if (!pod.running) begin
          state_d = POD_IDLE;
        end
      end
`endif
      default: state_d = POD_IDLE;
    endcase
  end

  // Restarting on every change discards any in-flight quotient of a stale velocity.
  assign div_start = (vel_d != vel_q);

  pod_seq_udiv #(
    .WIDTH   (VEL_W),
    .DIVISOR (POS_DIV)
  ) u_div (
    .clk_50Mhz (clk_50Mhz),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (vel_d),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quot)
  );

  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= POD_IDLE;
      pos_q   <= POS_INIT;
      vel_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      vel_q   <= vel_d;
      step_q  <= step_d;
    end
  end

  assign pod.position = pos_q;
  assign pod.velocity = vel_q;
  assign pod.pos_step = step_q;
  assign pod.state    = state_q;
`ifdef POD_LIMIT_EN
  assign pod.at_limit = (state_q == POD_LIMIT);
`else
  assign pod.at_limit = 1'b0;
`endif

endmodule

// File: tb/tb_pod_kinematics_integrator.sv
// tb/tb_pod_kinematics_integrator.sv - directed and randomized bench against a tick-level pod model
// Instance a uses default limits, instance b has VEL_MAX=1000 and POS_LIMIT=1000.
module tb_pod_kinematics_integrator;

  localparam int          CLK_HZ      = 10_000;
  localparam int          VEL_TICK_HZ = 10;
  localparam int          POS_TICK_HZ = 100;
  localparam int          POS_DIV     = 100;
  localparam int          VEL_PER     = CLK_HZ / VEL_TICK_HZ;
  localparam int          POS_PER     = CLK_HZ / POS_TICK_HZ;
  localparam int          DIV_LAT     = 32 + 2;
  localparam logic [63:0] POS_INIT    = 64'd15_240_000_000;
`ifdef POD_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pod_kinematics_integrator_if #(.ACC_W(32), .VEL_W(32), .POS_W(64)) bus_a ();
  pod_kinematics_integrator_if #(.ACC_W(32), .VEL_W(32), .POS_W(64)) bus_b ();

  pod_kinematics_integrator #(
    .CLK_HZ(CLK_HZ), .VEL_TICK_HZ(VEL_TICK_HZ), .POS_TICK_HZ(POS_TICK_HZ), .POS_DIV(POS_DIV)
  ) u_a (
    .clk_50Mhz (clk),
    .rst_n     (rst_n),
    .pod       (bus_a)
  );

  pod_kinematics_integrator #(
    .CLK_HZ(CLK_HZ), .VEL_TICK_HZ(VEL_TICK_HZ), .POS_TICK_HZ(POS_TICK_HZ), .POS_DIV(POS_DIV),
    .VEL_MAX(32'd1000), .POS_LIMIT(64'd1000)
  ) u_b (
    .clk_50Mhz (clk),
    .rst_n     (rst_n),
    .pod       (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;

  logic [63:0] m_pos[2];
  logic [31:0] m_vel[2];
  logic [31:0] m_step[2];
  logic [1:0]  m_state[2];
  int          m_k[2];
  bit          m_pend[2];
  int          m_pend_due[2];
  logic [31:0] m_pend_val[2];
  logic [31:0] m_vmax[2];
  logic [63:0] m_limit[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset(input int i);
    m_pos[i]   = POS_INIT;
    m_vel[i]   = '0;
    m_step[i]  = '0;
    m_state[i] = 2'd0;
    m_k[i]     = 0;
    m_pend[i]  = 1'b0;
  endtask

  // One clock edge of the pod rules: ticks counted from RUN entry, quotient lands DIV_LAT later.
  task automatic model_edge(input int i, input logic signed [31:0] acc, input logic run,
                            input logic ld, input logic [63:0] lpos);
    logic [31:0] v0, vn, old_step;
    logic [64:0] ps;
    longint      s;
    v0       = m_vel[i];
    vn       = v0;
    old_step = m_step[i];
    if (m_pend[i] && m_pend_due[i] == t) begin
      m_step[i] = m_pend_val[i];
      m_pend[i] = 1'b0;
    end
    if (m_state[i] == 2'd0) begin
      if (ld) begin
        m_pos[i]  = lpos;
        vn        = '0;
        m_step[i] = '0;
      end
      if (run) begin
        m_state[i] = 2'd1;
        m_k[i]     = 0;
      end
    end else if (m_state[i] == 2'd1) begin
      if (!run) begin
        m_state[i] = 2'd0;
      end else begin
        m_k[i]++;
        if (m_k[i] % VEL_PER == 0) begin
          s = longint'(v0) + longint'(acc);
          if (s < 0) vn = '0;
          else if (s > longint'(m_vmax[i])) vn = m_vmax[i];
          else vn = s[31:0];
        end
        if (m_k[i] % POS_PER == 0) begin
          ps = {1'b0, m_pos[i]} + 65'(old_step);
          if (LIMIT_EN && ps >= {1'b0, m_limit[i]}) begin
            m_pos[i]   = m_limit[i];
            vn         = '0;
            m_step[i]  = '0;
            m_state[i] = 2'd2;
          end else begin
            m_pos[i] = ps[63:0];
          end
        end
      end
    end else if (!run) begin
      m_state[i] = 2'd0;
    end
    if (vn != v0) begin
      m_vel[i]      = vn;
      m_pend[i]     = 1'b1;
      m_pend_due[i] = t + DIV_LAT;
      m_pend_val[i] = vn / POS_DIV;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      t++;
      model_edge(0, bus_a.accel, bus_a.running, bus_a.load, bus_a.load_pos);
      model_edge(1, bus_b.accel, bus_b.running, bus_b.load, bus_b.load_pos);
      #1;
    end
  endtask

  task automatic compare_dut(input int i, input string tag);
    if (i == 0) begin
      check({tag, "_a_pos"},   bus_a.position, m_pos[0]);
      check({tag, "_a_vel"},   bus_a.velocity, m_vel[0]);
      check({tag, "_a_step"},  bus_a.pos_step, m_step[0]);
      check({tag, "_a_state"}, bus_a.state,    m_state[0]);
      check({tag, "_a_lim"},   bus_a.at_limit, m_state[0] == 2'd2);
    end else begin
      check({tag, "_b_pos"},   bus_b.position, m_pos[1]);
      check({tag, "_b_vel"},   bus_b.velocity, m_vel[1]);
      check({tag, "_b_step"},  bus_b.pos_step, m_step[1]);
      check({tag, "_b_state"}, bus_b.state,    m_state[1]);
      check({tag, "_b_lim"},   bus_b.at_limit, m_state[1] == 2'd2);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pos_a"},   bus_a.position, POS_INIT);
    check({tag, "_vel_a"},   bus_a.velocity, 64'd0);
    check({tag, "_step_a"},  bus_a.pos_step, 64'd0);
    check({tag, "_state_a"}, bus_a.state,    64'd0);
    check({tag, "_lim_a"},   bus_a.at_limit, 64'd0);
    check({tag, "_pos_b"},   bus_b.position, POS_INIT);
    check({tag, "_vel_b"},   bus_b.velocity, 64'd0);
  endtask

  task automatic load_pulse(input int i, input logic [63:0] lpos);
    if (i == 0) begin
      bus_a.load_pos = lpos;
      bus_a.load     = 1'b1;
    end else begin
      bus_b.load_pos = lpos;
      bus_b.load     = 1'b1;
    end
    cyc(1);
    bus_a.load = 1'b0;
    bus_b.load = 1'b0;
  endtask

  initial begin
    int r;
    m_vmax[0]  = 32'hFFFF_FFFF;
    m_limit[0] = 64'd381_000_000_000;
    m_vmax[1]  = 32'd1000;
    m_limit[1] = 64'd1000;
    rst_n = 1'b0;
    bus_a.accel = '0; bus_a.running = 1'b0; bus_a.load = 1'b0; bus_a.load_pos = '0;
    bus_b.accel = '0; bus_b.running = 1'b0; bus_b.load = 1'b0; bus_b.load_pos = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    rst_n = 1'b1;
    model_reset(0);
    model_reset(1);

    // Reset mid-run at velocity 500
    bus_a.accel   = 32'sd500;
    bus_a.running = 1'b1;
    cyc(VEL_PER + 1);
    check("t1_vel500", bus_a.velocity, 64'd500);
    cyc(37);
    #2 rst_n = 1'b0;
    #1 check_reset_values("t1_rst");
    bus_a.running = 1'b0;
    bus_a.accel   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset(0);
    model_reset(1);

    // Ten ticks of accel 5, then freeze
    bus_a.accel   = 32'sd5;
    bus_a.running = 1'b1;
    cyc(10 * VEL_PER + 1);
    check("t2_vel50", bus_a.velocity, 64'd50);
    compare_dut(0, "t2_run");
    bus_a.running = 1'b0;
    cyc(2);
    check("t2_idle", bus_a.state, 64'd0);
    cyc(VEL_PER + 500);
    check("t2_hold", bus_a.velocity, 64'd50);
    compare_dut(0, "t2_hold");

    // Deceleration floors at zero
    bus_a.accel   = -32'sd40;
    bus_a.running = 1'b1;
    cyc(VEL_PER + 1);
    check("t3_vel10", bus_a.velocity, 64'd10);
    bus_a.accel = -32'sd5;
    cyc(VEL_PER);
    check("t3_vel5", bus_a.velocity, 64'd5);
    cyc(VEL_PER);
    check("t3_vel0", bus_a.velocity, 64'd0);
    cyc(VEL_PER);
    check("t3_vel0b", bus_a.velocity, 64'd0);
    bus_a.running = 1'b0;
    cyc(2);

    // Preload, divider latency, position integration
    load_pulse(0, 64'd0);
    check("t4_load", bus_a.position, 64'd0);
    bus_a.accel   = 32'sd1000;
    bus_a.running = 1'b1;
    cyc(VEL_PER + 1);
    check("t4_vel1000", bus_a.velocity, 64'd1000);
    bus_a.accel = '0;
    cyc(DIV_LAT - 1);
    check("t4_step_early", bus_a.pos_step, 64'd0);
    cyc(1);
    check("t4_step10", bus_a.pos_step, 64'd10);
    cyc(10 * VEL_PER - DIV_LAT);
    check("t4_pos1000", bus_a.position, 64'd1000);
    compare_dut(0, "t4_run");
    load_pulse(0, 64'd12345);
    compare_dut(0, "t4_load_in_run");
    bus_a.running = 1'b0;
    cyc(2);

    // Velocity ceiling on instance b
    load_pulse(1, 64'd0);
    bus_b.accel   = 32'sd990;
    bus_b.running = 1'b1;
    cyc(VEL_PER + 1);
    check("t5_vel990", bus_b.velocity, 64'd990);
    bus_b.accel = 32'sd50;
    cyc(VEL_PER);
    check("t5_vel_max", bus_b.velocity, 64'd1000);
    cyc(VEL_PER);
    check("t5_vel_max2", bus_b.velocity, 64'd1000);
    compare_dut(1, "t5");
    bus_b.running = 1'b0;
    cyc(2);

    // Track end
    load_pulse(1, 64'd995);
    bus_b.accel   = 32'sd1000;
    bus_b.running = 1'b1;
    cyc(VEL_PER + 1);
    bus_b.accel = '0;
    cyc(POS_PER);
`ifdef POD_LIMIT_EN
    check("t6_pos_lim", bus_b.position, 64'd1000);
    check("t6_vel_lim", bus_b.velocity, 64'd0);
    check("t6_state",   bus_b.state,    64'd2);
    check("t6_at_lim",  bus_b.at_limit, 64'd1);
`else
    check("t6_pos_wrap", bus_b.position, 64'd1005);
    check("t6_state",    bus_b.state,    64'd1);
    check("t6_at_lim",   bus_b.at_limit, 64'd0);
`endif
    compare_dut(1, "t6");
    bus_b.running = 1'b0;
    cyc(2);
    check("t6_idle", bus_b.state, 64'd0);
    check("t6_lim_clr", bus_b.at_limit, 64'd0);

    // Randomized segments on both instances
    for (int seg = 0; seg < 25; seg++) begin
      bus_a.running = ($urandom_range(0, 3) != 0);
      bus_b.running = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        bus_a.accel = $urandom;
      end else begin
        r = $urandom_range(0, 600);
        bus_a.accel = r - 300;
      end
      r = $urandom_range(0, 1200);
      bus_b.accel = r - 600;
      if ($urandom_range(0, 3) == 0) load_pulse(0, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) load_pulse(1, 64'($urandom_range(0, 900)));
      cyc($urandom_range(200, 1500));
      compare_dut(0, "rnd");
      compare_dut(1, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
